// File: rtl/alu_arbiter_pkg.sv
// Shared types and opcode constants for the ALU arbiter slice.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 4'b0000;
    localparam alu_op_t ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_EXEC,
        ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the ALU arbiter.
// Both channels are valid/ready: a beat transfers on a rising edge where valid and ready are both high.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*4-1:0] req_opcode;
    logic [NUM_REQ*8-1:0] req_operand_0;
    logic [NUM_REQ*8-1:0] req_operand_1;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [7:0]           rsp_result;

    modport master (
        output req_valid, req_opcode, req_operand_0, req_operand_1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_opcode, req_operand_0, req_operand_1, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping around.
module rr_pick #(
    parameter  int N     = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    int cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        // Offset 1..N keeps the previous winner last in line.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external add/sub ALU between NUM_REQ requesters, one operation at a time.
// Sequence per operation: IDLE (accept) -> EXEC (capture ALU result) -> RESP (hold until taken).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output alu_op_t       alu_opcode,
    output logic [7:0]    alu_operand_0,
    output logic [7:0]    alu_operand_1,
    input  logic [7:0]    alu_result,
    output arb_state_t    dbg_state
);
    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] cur_grant_q, cur_grant_d;
    alu_op_t          alu_opcode_q, alu_opcode_d;
    logic [7:0]       operand_0_q, operand_0_d;
    logic [7:0]       operand_1_q, operand_1_d;
    logic [7:0]       rsp_result_q, rsp_result_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req  (bus.req_valid),
        .last (last_grant_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cur_grant_d   = cur_grant_q;
        alu_opcode_d  = alu_opcode_q;
        operand_0_d   = operand_0_q;
        operand_1_d   = operand_1_q;
        rsp_result_d  = rsp_result_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    bus.req_ready[pick_idx] = 1'b1;
                    cur_grant_d  = pick_idx;
                    alu_opcode_d = bus.req_opcode[int'(pick_idx)*4 +: 4];
                    operand_0_d  = bus.req_operand_0[int'(pick_idx)*8 +: 8];
                    operand_1_d  = bus.req_operand_1[int'(pick_idx)*8 +: 8];
                    state_d      = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                rsp_result_d = alu_result;
                state_d      = ARB_RESP;
            end
            ARB_RESP: begin
                bus.rsp_valid[cur_grant_q] = 1'b1;
                // Fairness pointer only advances once the response is taken.
                if (bus.rsp_ready[cur_grant_q]) begin
                    last_grant_d = cur_grant_q;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cur_grant_q  <= '0;
            alu_opcode_q <= '0;
            operand_0_q  <= '0;
            operand_1_q  <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_grant_q  <= cur_grant_d;
            alu_opcode_q <= alu_opcode_d;
            operand_0_q  <= operand_0_d;
            operand_1_q  <= operand_1_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign alu_opcode     = alu_opcode_q;
    assign alu_operand_0  = operand_0_q;
    assign alu_operand_1  = operand_1_q;
    assign bus.rsp_result = rsp_result_q;
    assign dbg_state      = state_q;
endmodule
